fetch_decode_unit: RTL and testbench
====================================

Name: fetch_decode_unit

Overview:
Front-end controller of the 4-bit CPU.
- Owns the program counter and drives the address input of the synchronous instruction ROM (one-cycle registered read).
- Captures the returned 8-bit word into an instruction register and splits it into opcode[7:4] and operand[3:0].
- Hands each decoded instruction to the execute stage over a valid/ready handshake.
- Stops fetching on HALT.

Parameters:
ADDR_W, 4, program counter / ROM address width (16-entry program space)
INSTR_W, 8, instruction width; opcode = upper 4 bits, operand = lower 4 bits
RESET_PC, 0, PC value loaded on reset and on run from IDLE/HALTED

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  start pulse; honoured only in IDLE or HALTED
pc_addr  output  ADDR_W  address to instruction ROM, driven directly from PC register
instruction_in  input  INSTR_W  ROM data, valid the cycle after pc_addr was presented
exec_valid  output  1  decoded instruction available to execute stage
exec_opcode  output  4  IR[7:4]
exec_operand  output  4  IR[3:0]
exec_ready  input  1  execute stage accepts instruction when high with exec_valid
busy  output  1  high in FETCH, LOAD, ISSUE
halted  output  1  high in HALTED
illegal_op  output  1  sticky flag: an unknown opcode was issued

Behaviour:
- Opcodes (shared constants): NOP 4'b0000, MOV 4'b0101, ADD 4'b1000, HALT 4'b1111. All others are illegal.
- Reset (async, any state, including mid-handshake):
  - State to IDLE, PC = RESET_PC, IR = 0.
  - exec_valid = 0, busy = 0, halted = 0, illegal_op = 0.
  - pc_addr therefore reads RESET_PC.
- States: IDLE, FETCH, LOAD, ISSUE, HALTED.
- IDLE:
  - Outputs idle.
  - run=1 -> PC = RESET_PC, go to FETCH.
- FETCH:
  - pc_addr = PC is stable; the ROM samples it at the end of this cycle.
  - Always go to LOAD.
- LOAD:
  - instruction_in is valid; IR <= instruction_in at the end of the cycle.
  - If instruction_in[7:4] == HALT -> go to HALTED (HALT is never issued). Otherwise -> go to ISSUE.
- ISSUE:
  - exec_valid = 1; exec_opcode and exec_operand are driven from IR and held stable until accepted.
  - exec_valid && exec_ready -> PC <= PC + 1, go to FETCH.
  - Otherwise stay in ISSUE (stall of any length; no outputs change).
  - On acceptance of an illegal opcode, illegal_op <= 1, sticky until reset or run.
  - Illegal opcodes are still issued; the execute stage treats them as NOP.
- HALTED:
  - halted = 1; PC holds the address of the HALT word; no ROM fetches change state.
  - run=1 -> clear halted and illegal_op, PC = RESET_PC, go to FETCH.
- Latency:
  - run accepted in cycle 0 -> FETCH in cycle 1, LOAD in cycle 2, exec_valid first high in cycle 3.
  - With exec_ready tied high, each instruction costs 3 cycles.
- PC arithmetic: modulo 2^ADDR_W. Acceptance at PC = 15 wraps PC to 0 with no flag.
- run outside IDLE/HALTED is ignored.
- IR updates only in LOAD, so exec fields never glitch while stalled.

Decomposition:
- Shared package/header holds:
  - the opcode constants;
  - the field positions (OPC_HI=7, OPC_LO=4, OPR_HI=3, OPR_LO=0);
  - the state encoding (3-bit localparams).
- No sub-module is needed. PC, IR and FSM stay in one module. An optional decode function maps opcode to legal/halt bits.

Test Plan:
1. ROM = {0x52, 0x57, 0x81, 0xF0}, exec_ready=1, pulse run:
   - exec_valid high in cycles 3, 6, 9 with (5,2), (5,7), (8,1).
   - halted=1 from cycle 12 and stays; pc_addr holds 3.
2. Same program, exec_ready=0 for 5 cycles during the first ISSUE:
   - exec_valid and (5,2) held stable throughout; pc_addr stays 0.
   - Advances only on the ready cycle; second issue occurs 3 cycles later.
3. ROM filled with 0x00 (NOP), exec_ready=1, run:
   - PC sequence 0..15 then 0 (wrap).
   - Never halts; illegal_op=0.
4. ROM[0] = 0x3A, ROM[1] = 0xF0:
   - 0x3A issued as (3,A); illegal_op=1 after acceptance, remains 1 in HALTED.
   - A run pulse clears it and restarts at PC 0.
5. Assert rst during ISSUE with exec_ready=0:
   - Immediately (before next edge) exec_valid=0, pc_addr=0, busy=0.
   - State is IDLE; no fetch occurs until run.
6. Pulse run while busy in FETCH/ISSUE: no restart, PC unchanged, program completes normally.

Source files
------------

// File: rtl/fetch_decode_unit_pkg.sv
// rtl/fetch_decode_unit_pkg.sv - shared constants and decode helpers for the fetch/decode front end
//
// Purpose: opcode constants, instruction field positions, FSM state encoding
//          and small opcode classification functions shared by the RTL.
// Ports:   none (package).
package fetch_decode_unit_pkg;

  localparam int ADDR_W_DEF  = 4;
  localparam int INSTR_W_DEF = 8;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 4;
  localparam int OPR_HI = 3;
  localparam int OPR_LO = 0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_LOAD   = ST_LOAD,
    S_ISSUE  = ST_ISSUE,
    S_HALTED = ST_HALTED
  } state_e;

  // HALT is decoded separately: it stops the front end and is never issued.
  function automatic logic is_halt_op(input logic [3:0] opc);
    return opc == OP_HALT;
  endfunction

  function automatic logic is_legal_op(input logic [3:0] opc);
    return (opc == OP_NOP) || (opc == OP_MOV) || (opc == OP_ADD) || (opc == OP_HALT);
  endfunction

endpackage

// File: rtl/fetch_decode_unit_if.sv
// rtl/fetch_decode_unit_if.sv - control, ROM and execute-stage signals of the fetch/decode unit
//
// Purpose: bundles the run/status, instruction ROM and execute handshake signals.
// Signals: run, pc_addr, instruction_in, exec_valid, exec_opcode, exec_operand,
//          exec_ready, busy, halted, illegal_op.
// Modports: master = fetch/decode unit, slave = ROM / execute stage / controller.
interface fetch_decode_unit_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
);
  logic               run;
  logic [ADDR_W-1:0]  pc_addr;
  logic [INSTR_W-1:0] instruction_in;
  logic               exec_valid;
  logic [3:0]         exec_opcode;
  logic [3:0]         exec_operand;
  logic               exec_ready;
  logic               busy;
  logic               halted;
  logic               illegal_op;

  modport master (
    input  run, instruction_in, exec_ready,
    output pc_addr, exec_valid, exec_opcode, exec_operand, busy, halted, illegal_op
  );

  modport slave (
    output run, instruction_in, exec_ready,
    input  pc_addr, exec_valid, exec_opcode, exec_operand, busy, halted, illegal_op
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - program counter, instruction register and fetch/issue FSM
//
// Purpose: fetches words from a one-cycle synchronous ROM, latches them into IR,
//          issues opcode/operand to the execute stage over valid/ready and stops on HALT.
// Ports:   clk  - clock, rising edge
//          rst  - asynchronous active-high reset
//          bus  - fetch_decode_unit_if.master (run, ROM address/data, execute
//                 handshake, busy/halted/illegal_op status)
module fetch_decode_unit
  import fetch_decode_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst,
  fetch_decode_unit_if.master bus
);

  state_e             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic               valid_q;
  logic               busy_q;
  logic               halted_q;
  logic               illegal_q;

  logic [3:0] load_opc;
  logic [3:0] ir_opc;

  assign load_opc = bus.instruction_in[OPC_HI:OPC_LO];
  assign ir_opc   = ir_q[OPC_HI:OPC_LO];

  // Status outputs are flops updated alongside the state so they change only
  // on clock edges (or immediately on reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (bus.run) begin
            pc_q      <= RESET_PC;
            state_q   <= S_FETCH;
            busy_q    <= 1'b1;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
          end
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          ir_q <= bus.instruction_in;
          if (is_halt_op(load_opc)) begin
            // PC keeps pointing at the HALT word.
            state_q  <= S_HALTED;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_ISSUE;
            valid_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (bus.exec_ready) begin
            pc_q    <= pc_q + ADDR_W'(1);
            state_q <= S_FETCH;
            valid_q <= 1'b0;
            if (!is_legal_op(ir_opc)) begin
              illegal_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_addr      = pc_q;
  assign bus.exec_valid   = valid_q;
  assign bus.exec_opcode  = ir_opc;
  assign bus.exec_operand = ir_q[OPR_HI:OPR_LO];
  assign bus.busy         = busy_q;
  assign bus.halted       = halted_q;
  assign bus.illegal_op   = illegal_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb/tb_fetch_decode_unit.sv - directed self-checking bench for fetch_decode_unit
module tb_fetch_decode_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] rom [16];

  fetch_decode_unit_if #(.ADDR_W(4), .INSTR_W(8)) bus ();

  fetch_decode_unit #(.ADDR_W(4), .INSTR_W(8), .RESET_PC(4'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for the address presented in one cycle appears in the next.
  always @(posedge clk) bus.instruction_in <= rom[bus.pc_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.run = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Leaves the bench in cycle 1 (first FETCH) relative to the run cycle 0.
  task automatic pulse_run();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
  endtask

  task automatic load_prog1();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h52; rom[1] = 8'h57; rom[2] = 8'h81; rom[3] = 8'hF0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.exec_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.exec_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    checks++; if (bus.illegal_op !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal_op); end
    checks++; if (bus.pc_addr !== 4'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", bus.pc_addr); end
    checks++; if ({bus.exec_opcode, bus.exec_operand} !== 8'h00) begin failures++; $display("FAIL reset_ir got=%h exp=00", {bus.exec_opcode, bus.exec_operand}); end
  endtask

  task automatic test_program();
    logic [7:0] exp_ir [3];
    logic exp_v, exp_h;
    int   exp_pc;
    exp_ir[0] = 8'h52; exp_ir[1] = 8'h57; exp_ir[2] = 8'h81;
    do_reset();
    load_prog1();
    bus.exec_ready = 1'b1;
    pulse_run();
    for (int c = 1; c <= 15; c++) begin
      exp_v  = (c == 3) || (c == 6) || (c == 9);
      exp_h  = (c >= 12);
      exp_pc = ((c - 1) / 3 > 3) ? 3 : (c - 1) / 3;
      checks++; if (bus.exec_valid !== exp_v) begin failures++; $display("FAIL prog_valid c=%0d got=%b exp=%b", c, bus.exec_valid, exp_v); end
      checks++; if (bus.halted !== exp_h) begin failures++; $display("FAIL prog_halted c=%0d got=%b exp=%b", c, bus.halted, exp_h); end
      checks++; if (bus.busy !== !exp_h) begin failures++; $display("FAIL prog_busy c=%0d got=%b exp=%b", c, bus.busy, !exp_h); end
      checks++; if (bus.pc_addr !== 4'(exp_pc)) begin failures++; $display("FAIL prog_pc c=%0d got=%0d exp=%0d", c, bus.pc_addr, exp_pc); end
      if (exp_v) begin
        checks++;
        if ({bus.exec_opcode, bus.exec_operand} !== exp_ir[c/3 - 1]) begin
          failures++; $display("FAIL prog_ir c=%0d got=%h exp=%h", c, {bus.exec_opcode, bus.exec_operand}, exp_ir[c/3 - 1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    bit seen;
    do_reset();
    load_prog1();
    bus.exec_ready = 1'b0;
    pulse_run();
    tick(); tick();
    for (int c = 3; c <= 7; c++) begin
      checks++; if (bus.exec_valid !== 1'b1) begin failures++; $display("FAIL stall_valid c=%0d got=%b exp=1", c, bus.exec_valid); end
      checks++; if ({bus.exec_opcode, bus.exec_operand} !== 8'h52) begin failures++; $display("FAIL stall_ir c=%0d got=%h exp=52", c, {bus.exec_opcode, bus.exec_operand}); end
      checks++; if (bus.pc_addr !== 4'd0) begin failures++; $display("FAIL stall_pc c=%0d got=%0d exp=0", c, bus.pc_addr); end
      tick();
    end
    bus.exec_ready = 1'b1;
    checks++; if (bus.exec_valid !== 1'b1) begin failures++; $display("FAIL stall_ready_cycle got=%b exp=1", bus.exec_valid); end
    tick();
    checks++; if (bus.exec_valid !== 1'b0 || bus.pc_addr !== 4'd1) begin failures++; $display("FAIL stall_advance got valid=%b pc=%0d exp valid=0 pc=1", bus.exec_valid, bus.pc_addr); end
    tick(); tick();
    checks++; if (bus.exec_valid !== 1'b1 || {bus.exec_opcode, bus.exec_operand} !== 8'h57) begin failures++; $display("FAIL stall_second got valid=%b ir=%h exp valid=1 ir=57", bus.exec_valid, {bus.exec_opcode, bus.exec_operand}); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = bus.halted;
    end
    checks++; if (!seen) begin failures++; $display("FAIL stall_halt_timeout got halted=%b exp=1", bus.halted); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    bus.exec_ready = 1'b1;
    pulse_run();
    for (int k = 0; k <= 16; k++) begin
      checks++; if (bus.pc_addr !== 4'(k % 16) || bus.busy !== 1'b1) begin failures++; $display("FAIL wrap_pc k=%0d got pc=%0d busy=%b exp pc=%0d busy=1", k, bus.pc_addr, bus.busy, k % 16); end
      tick(); tick();
      checks++; if (bus.exec_valid !== 1'b1 || bus.exec_opcode !== 4'h0) begin failures++; $display("FAIL wrap_issue k=%0d got valid=%b opc=%h exp valid=1 opc=0", k, bus.exec_valid, bus.exec_opcode); end
      tick();
    end
    checks++; if (bus.halted !== 1'b0 || bus.illegal_op !== 1'b0) begin failures++; $display("FAIL wrap_flags got halted=%b illegal=%b exp 0 0", bus.halted, bus.illegal_op); end
  endtask

  task automatic test_illegal();
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h3A; rom[1] = 8'hF0;
    bus.exec_ready = 1'b1;
    pulse_run();
    tick(); tick();
    checks++; if (bus.exec_valid !== 1'b1 || {bus.exec_opcode, bus.exec_operand} !== 8'h3A) begin failures++; $display("FAIL ill_issue got valid=%b ir=%h exp valid=1 ir=3a", bus.exec_valid, {bus.exec_opcode, bus.exec_operand}); end
    checks++; if (bus.illegal_op !== 1'b0) begin failures++; $display("FAIL ill_before_accept got=%b exp=0", bus.illegal_op); end
    tick();
    checks++; if (bus.illegal_op !== 1'b1) begin failures++; $display("FAIL ill_after_accept got=%b exp=1", bus.illegal_op); end
    tick(); tick();
    checks++; if (bus.halted !== 1'b1 || bus.illegal_op !== 1'b1 || bus.pc_addr !== 4'd1) begin failures++; $display("FAIL ill_halted got halted=%b illegal=%b pc=%0d exp 1 1 1", bus.halted, bus.illegal_op, bus.pc_addr); end
    tick(); tick();
    checks++; if (bus.halted !== 1'b1 || bus.illegal_op !== 1'b1) begin failures++; $display("FAIL ill_sticky got halted=%b illegal=%b exp 1 1", bus.halted, bus.illegal_op); end
    pulse_run();
    checks++; if (bus.illegal_op !== 1'b0 || bus.halted !== 1'b0 || bus.pc_addr !== 4'd0 || bus.busy !== 1'b1) begin failures++; $display("FAIL ill_rerun got illegal=%b halted=%b pc=%0d busy=%b exp 0 0 0 1", bus.illegal_op, bus.halted, bus.pc_addr, bus.busy); end
    tick(); tick();
    checks++; if (bus.exec_valid !== 1'b1 || {bus.exec_opcode, bus.exec_operand} !== 8'h3A) begin failures++; $display("FAIL ill_rerun_issue got valid=%b ir=%h exp valid=1 ir=3a", bus.exec_valid, {bus.exec_opcode, bus.exec_operand}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_prog1();
    bus.exec_ready = 1'b1;
    pulse_run();
    tick(); tick();
    tick();
    bus.exec_ready = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus.exec_valid !== 1'b1 || bus.pc_addr !== 4'd1) begin failures++; $display("FAIL rstmid_pre got valid=%b pc=%0d exp valid=1 pc=1", bus.exec_valid, bus.pc_addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.exec_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", bus.exec_valid); end
    checks++; if (bus.pc_addr !== 4'd0) begin failures++; $display("FAIL rstmid_pc got=%0d exp=0", bus.pc_addr); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    #2 rst = 1'b0;
    bus.exec_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.busy !== 1'b0 || bus.exec_valid !== 1'b0 || bus.pc_addr !== 4'd0) begin failures++; $display("FAIL rstmid_idle i=%0d got busy=%b valid=%b pc=%0d exp 0 0 0", i, bus.busy, bus.exec_valid, bus.pc_addr); end
      tick();
    end
  endtask

  task automatic test_run_ignored();
    do_reset();
    load_prog1();
    bus.exec_ready = 1'b1;
    pulse_run();
    tick(); tick(); tick();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    checks++; if (bus.pc_addr !== 4'd1 || bus.busy !== 1'b1 || bus.exec_valid !== 1'b0) begin failures++; $display("FAIL runign_fetch got pc=%0d busy=%b valid=%b exp 1 1 0", bus.pc_addr, bus.busy, bus.exec_valid); end
    tick();
    checks++; if (bus.exec_valid !== 1'b1 || {bus.exec_opcode, bus.exec_operand} !== 8'h57) begin failures++; $display("FAIL runign_issue2 got valid=%b ir=%h exp valid=1 ir=57", bus.exec_valid, {bus.exec_opcode, bus.exec_operand}); end
    tick(); tick(); tick();
    checks++; if (bus.exec_valid !== 1'b1 || {bus.exec_opcode, bus.exec_operand} !== 8'h81) begin failures++; $display("FAIL runign_issue3 got valid=%b ir=%h exp valid=1 ir=81", bus.exec_valid, {bus.exec_opcode, bus.exec_operand}); end
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    checks++; if (bus.pc_addr !== 4'd3) begin failures++; $display("FAIL runign_pc got=%0d exp=3", bus.pc_addr); end
    tick(); tick();
    checks++; if (bus.halted !== 1'b1 || bus.pc_addr !== 4'd3) begin failures++; $display("FAIL runign_halt got halted=%b pc=%0d exp 1 3", bus.halted, bus.pc_addr); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    bus.run = 1'b0;
    bus.exec_ready = 1'b0;
    test_reset();
    test_program();
    test_stall();
    test_wrap();
    test_illegal();
    test_reset_mid();
    test_run_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
